// File: rtl/terminal_writer_pkg.sv
// Shared constants, state encoding and address helper
// for the text-terminal write side.
package terminal_writer_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 40;
  localparam int ADDR_W = 12;

  localparam logic [7:0] BLANK = 8'd0;
  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  localparam logic [ADDR_W-1:0] A_COLS  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] A_SCRL  = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] A_CELLS = ADDR_W'(COLS * ROWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCROLL,
    S_CLR_ROW,
    S_CLR_ALL
  } state_e;

  function automatic logic [ADDR_W-1:0] cell_addr(
    input logic [5:0] row,
    input logic [6:0] col
  );
    return ADDR_W'(row) * A_COLS + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/terminal_writer_if.sv
// Byte-stream input, videoBuf write/read port
// and cursor status of the terminal writer.
interface terminal_writer_if;
  import terminal_writer_pkg::*;

  logic [7:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;
  logic [ADDR_W-1:0] buf_raddr;
  logic [7:0]        buf_rdata;
  logic [6:0]        cursor_col;
  logic [5:0]        cursor_row;
  logic              busy;

  modport slave (
    input  char_in, char_valid, buf_rdata,
    output char_ready, buf_we, buf_waddr,
    output buf_wdata, buf_raddr,
    output cursor_col, cursor_row, busy
  );

  modport master (
    output char_in, char_valid, buf_rdata,
    input  char_ready, buf_we, buf_waddr,
    input  buf_wdata, buf_raddr,
    input  cursor_col, cursor_row, busy
  );

endinterface

// File: rtl/terminal_writer.sv
// Cursor-tracking writer for the 80x40 videoBuf:
// prints, handles BS/LF/CR/FF, scrolls and clears.
module terminal_writer
  import terminal_writer_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  terminal_writer_if.slave tw
);

  state_e            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              wsel_q, wsel_d;
  logic              accept;

  assign accept = tw.char_valid && (state_q == S_IDLE);

  // Next state, cursor and registered buffer port
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    wsel_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (tw.char_in == CC_CR): col_d = '0;
            (tw.char_in == CC_LF): begin
              col_d = '0;
              if (row_q == LAST_ROW) begin
                state_d = S_SCROLL;
                cnt_d   = '0;
                raddr_d = A_COLS;
              end else begin
                row_d = row_q + 1'b1;
              end
            end
            (tw.char_in == CC_BS): begin
              if (col_q != '0) col_d = col_q - 1'b1;
            end
            (tw.char_in == CC_FF): begin
              state_d = S_CLR_ALL;
              we_d    = 1'b1;
              waddr_d = '0;
              wdata_d = BLANK;
              cnt_d   = ADDR_W'(1);
              col_d   = '0;
              row_d   = '0;
            end
            default: begin
              we_d    = 1'b1;
              waddr_d = cell_addr(row_q, col_q);
              wdata_d = tw.char_in;
              if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                  state_d = S_SCROLL;
                  cnt_d   = '0;
                  raddr_d = A_COLS;
                end else begin
                  row_d = row_q + 1'b1;
                end
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          endcase
        end
      end
      S_SCROLL: begin
        if (cnt_q == A_SCRL) begin
          state_d = S_CLR_ROW;
          we_d    = 1'b1;
          waddr_d = A_SCRL;
          wdata_d = BLANK;
          cnt_d   = ADDR_W'(1);
        end else begin
          we_d    = 1'b1;
          wsel_d  = 1'b1;
          waddr_d = cnt_q;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q < A_SCRL - 1'b1)
            raddr_d = cnt_q + A_COLS + 1'b1;
        end
      end
      S_CLR_ROW: begin
        if (cnt_q == A_COLS) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = A_SCRL + cnt_q;
          wdata_d = BLANK;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_CLR_ALL: begin
        if (cnt_q == A_CELLS) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = BLANK;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      wsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      wsel_q  <= wsel_d;
    end
  end

  // Scroll copies take the RAM read data straight through
  assign tw.buf_wdata  = wsel_q ? tw.buf_rdata : wdata_q;
  assign tw.buf_we     = we_q;
  assign tw.buf_waddr  = waddr_q;
  assign tw.buf_raddr  = raddr_q;
  assign tw.cursor_col = col_q;
  assign tw.cursor_row = row_q;
  assign tw.char_ready = (state_q == S_IDLE);
  assign tw.busy       = (state_q != S_IDLE);

endmodule
